// File: rtl/mapper_pkg.sv
// Shared definitions for the 2600 cartridge mappers: settle FSM states,
// address-bus widths and the mapper identifiers used by the cart2600 mux.
package mapper_pkg;

    localparam int MAPPER_ROM_AW = 19;
    localparam int MAPPER_RAM_AW = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } settle_state_t;

    localparam logic [7:0] BANKF8 = 8'h01;
    localparam logic [7:0] BANKF6 = 8'h02;
    localparam logic [7:0] BANKF4 = 8'h03;
    localparam logic [7:0] BANKEF = 8'h04;

    // Mapper ID for a hotspot mapper with 2^bank_bits banks of 4 KB.
    function automatic logic [7:0] hotspot_mapper_id(input int bank_bits);
        case (bank_bits)
            1:       return BANKF8;
            2:       return BANKF6;
            3:       return BANKF4;
            4:       return BANKEF;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/addr_settle_filter.sv
// Address-settle filter: emits a one-cycle commit once the cartridge address
// has been stable for SETTLE clocks after its last change.
module addr_settle_filter
    import mapper_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a_change,
    input  logic a12,
    output logic commit
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    settle_state_t state;
    logic [3:0]    cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else if (a_change) begin
            // Any address movement restarts the settle window.
            state <= ST_SETTLE;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                ST_SETTLE: begin
                    if (cnt == SETTLE_CNT) begin
                        state <= a12 ? ST_HOLD : ST_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_IDLE, ST_HOLD: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The commit edge is the one that leaves SETTLE with the count complete.
    assign commit = (state == ST_SETTLE) && (cnt == SETTLE_CNT) && !a_change;

endmodule

// File: rtl/mapper_hotspot_generic.sv
// Hotspot bank-switching mapper (F8/F6/F4/EF) with optional Superchip RAM,
// gated by an address-settle filter so glitching addresses never commit.
module mapper_hotspot_generic
    import mapper_pkg::*;
#(
    parameter int          BANK_BITS  = 1,
    parameter logic [12:0] HOT_HI     = 13'h1FF9,
    parameter int          RESET_BANK = (1 << BANK_BITS) - 1,
    parameter int          RAM_BITS   = 7,
    parameter int          SETTLE     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_change,
    input  logic                     sc,
    input  logic [12:0]              a_in,
    input  logic [7:0]               d_in,
    output logic [7:0]               d_out,
    output logic [15:0]              flags_out,
    output logic [7:0]               oe,
    output logic                     ram_sel,
    output logic                     ram_rw,
    output logic [MAPPER_RAM_AW-1:0] ram_a,
    output logic [MAPPER_ROM_AW-1:0] rom_a,
    output logic [6:0]               bank
);

    localparam int          RAM_SIZE = 1 << RAM_BITS;
    localparam logic [12:0] HOT_LO   = HOT_HI - 13'((1 << BANK_BITS) - 1);
    localparam logic [11:0] WR_END   = 12'(RAM_SIZE);
    localparam logic [11:0] RD_END   = 12'(2 * RAM_SIZE);

    if (BANK_BITS < 1 || BANK_BITS > 7) begin : g_bad_bank_bits
        $error("mapper_hotspot_generic: BANK_BITS must be 1..7");
    end
    if (RAM_BITS != 7 && RAM_BITS != 8) begin : g_bad_ram_bits
        $error("mapper_hotspot_generic: RAM_BITS must be 7 or 8");
    end
    if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
        $error("mapper_hotspot_generic: SETTLE must be 0..15");
    end
    if (!((int'(HOT_LO) >= 'h1000 + 2 * RAM_SIZE) || (int'(HOT_HI) < 'h1000))) begin : g_overlap
        $error("mapper_hotspot_generic: hotspot range overlaps the RAM windows");
    end

    logic                 a12;
    logic                 wr_win;
    logic                 rd_win;
    logic                 hot_hit;
    logic                 commit;
    logic [BANK_BITS-1:0] bank_q;
    logic                 unused_d;

    assign a12 = a_in[12];

    // Both RAM windows sit at the bottom of the 4 KB cartridge space.
    assign wr_win  = sc && a12 && (a_in[11:0] < WR_END);
    assign rd_win  = sc && a12 && (a_in[11:0] >= WR_END) && (a_in[11:0] < RD_END);
    assign hot_hit = (a_in >= HOT_LO) && (a_in <= HOT_HI);

    addr_settle_filter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .reset    (reset),
        .a_change (a_change),
        .a12      (a12),
        .commit   (commit)
    );

    // Hotspots switch on reads and writes alike: the slot has no R/W line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q <= BANK_BITS'(RESET_BANK);
        end else if (commit && hot_hit) begin
            bank_q <= BANK_BITS'(a_in - HOT_LO);
        end
    end

    // The write strobe spans exactly the cycle that ends on the commit edge,
    // so the RAM captures d_in at that edge and an aborted commit never writes.
    assign ram_rw = !(commit && wr_win);

    assign ram_sel   = wr_win || rd_win;
    assign ram_a     = MAPPER_RAM_AW'(a_in[RAM_BITS-1:0]);
    assign oe        = (a12 && !wr_win) ? 8'hFF : 8'h00;
    assign rom_a     = MAPPER_ROM_AW'({bank_q, a_in[11:0]});
    assign bank      = 7'(bank_q);
    assign d_out     = 8'h00;
    assign flags_out = 16'h0000;

    // Write data reaches the shared RAM directly; the mapper never looks at it.
    assign unused_d = ^d_in;

endmodule

// File: tb/tb_mapper_hotspot_generic.sv
// Scoreboard bench for mapper_hotspot_generic: an F8+Superchip instance is
// monitored for commit events, an EF instance is checked directly.
module tb_mapper_hotspot_generic;

    localparam logic [1:0] EV_NONE  = 2'd0;
    localparam logic [1:0] EV_BANK  = 2'd1;
    localparam logic [1:0] EV_WRITE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [13:0] val;
    } event_t;

    logic        clk;
    logic        reset;
    logic        a_change;
    logic        sc;
    logic [12:0] a_in;
    logic [7:0]  d_in;

    logic [7:0]  f8_d_out, ef_d_out;
    logic [15:0] f8_flags, ef_flags;
    logic [7:0]  f8_oe, ef_oe;
    logic        f8_ram_sel, ef_ram_sel;
    logic        f8_ram_rw, ef_ram_rw;
    logic [13:0] f8_ram_a, ef_ram_a;
    logic [18:0] f8_rom_a, ef_rom_a;
    logic [6:0]  f8_bank, ef_bank;

    int          errors = 0;
    int          checks = 0;
    event_t      sb[$];
    logic [12:0] prev_a;
    logic [6:0]  last_bank;

    mapper_hotspot_generic #(
        .BANK_BITS (1),
        .HOT_HI    (13'h1FF9),
        .RAM_BITS  (7),
        .SETTLE    (2)
    ) dut_f8 (
        .clk       (clk),
        .reset     (reset),
        .a_change  (a_change),
        .sc        (sc),
        .a_in      (a_in),
        .d_in      (d_in),
        .d_out     (f8_d_out),
        .flags_out (f8_flags),
        .oe        (f8_oe),
        .ram_sel   (f8_ram_sel),
        .ram_rw    (f8_ram_rw),
        .ram_a     (f8_ram_a),
        .rom_a     (f8_rom_a),
        .bank      (f8_bank)
    );

    mapper_hotspot_generic #(
        .BANK_BITS (4),
        .HOT_HI    (13'h1FEF),
        .RAM_BITS  (7),
        .SETTLE    (2)
    ) dut_ef (
        .clk       (clk),
        .reset     (reset),
        .a_change  (a_change),
        .sc        (sc),
        .a_in      (a_in),
        .d_in      (d_in),
        .d_out     (ef_d_out),
        .flags_out (ef_flags),
        .oe        (ef_oe),
        .ram_sel   (ef_ram_sel),
        .ram_rw    (ef_ram_rw),
        .ram_a     (ef_ram_a),
        .rom_a     (ef_rom_a),
        .bank      (ef_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one address for `hold` clock edges; the expected commit event
    // (if any) is queued before the edges happen.
    task automatic access(input logic [12:0] addr, input logic [7:0] d, input int hold,
                          input logic [1:0] kind, input logic [13:0] val);
        if (kind != EV_NONE) sb.push_back('{kind: kind, val: val});
        a_change = (addr != prev_a);
        a_in     = addr;
        d_in     = d;
        prev_a   = addr;
        repeat (hold) begin
            @(posedge clk);
            #1;
            a_change = 1'b0;
        end
    endtask

    // Monitor: every write strobe or bank change on the F8 instance is an event.
    always @(negedge clk) begin
        if (!reset) begin
            if (f8_ram_rw == 1'b0) begin
                check("oe_during_write", 32'(f8_oe), 32'h00);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_spurious_write: got ram_a 0x%0h, expected no event", f8_ram_a);
                end else begin
                    event_t e;
                    e = sb.pop_front();
                    check("sb_write_kind", 32'(EV_WRITE), 32'(e.kind));
                    check("sb_write_ram_a", 32'(f8_ram_a), 32'(e.val));
                end
            end
            if (f8_bank != last_bank) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_spurious_bank: got bank %0d, expected no event", f8_bank);
                end else begin
                    event_t e;
                    e = sb.pop_front();
                    check("sb_bank_kind", 32'(EV_BANK), 32'(e.kind));
                    check("sb_bank_value", 32'(f8_bank), 32'(e.val));
                end
            end
        end
        last_bank = f8_bank;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        a_change = 1'b0;
        sc       = 1'b0;
        a_in     = 13'h1234;
        d_in     = 8'h00;
        prev_a   = 13'h1234;
        repeat (3) @(posedge clk);
        #1;
        check("rst_f8_bank", 32'(f8_bank), 32'd1);
        check("rst_f8_rom_a", 32'(f8_rom_a), 32'h01234);
        check("rst_f8_ram_rw", 32'(f8_ram_rw), 32'd1);
        check("rst_f8_d_out", 32'(f8_d_out), 32'h00);
        check("rst_f8_flags", 32'(f8_flags), 32'h0000);
        check("rst_ef_bank", 32'(ef_bank), 32'd15);
        check("rst_ef_rom_a", 32'(ef_rom_a), 32'h0F234);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // F8 bank switching.
        access(13'h1FF8, 8'h00, 4, EV_BANK, 14'd0);
        check("f8_rom_a_bank0", 32'(f8_rom_a), 32'h00FF8);
        access(13'h1FF9, 8'h00, 4, EV_BANK, 14'd1);
        check("f8_rom_a_bank1", 32'(f8_rom_a), 32'h01FF9);

        // Glitch: hotspot held one clock short of committing.
        access(13'h1FF8, 8'h00, 3, EV_NONE, 14'd0);
        access(13'h1234, 8'h00, 4, EV_NONE, 14'd0);
        check("glitch_bank_kept", 32'(f8_bank), 32'd1);

        // Superchip write then read.
        sc = 1'b1;
        access(13'h1005, 8'hA5, 4, EV_WRITE, 14'd5);
        check("wr_oe", 32'(f8_oe), 32'h00);
        check("wr_ram_sel", 32'(f8_ram_sel), 32'd1);
        check("wr_ram_rw_idle", 32'(f8_ram_rw), 32'd1);
        access(13'h1085, 8'h00, 4, EV_NONE, 14'd0);
        check("rd_ram_sel", 32'(f8_ram_sel), 32'd1);
        check("rd_ram_rw", 32'(f8_ram_rw), 32'd1);
        check("rd_oe", 32'(f8_oe), 32'hFF);
        check("rd_ram_a", 32'(f8_ram_a), 32'd5);

        // EF hotspot edges.
        access(13'h1FE0, 8'h00, 4, EV_NONE, 14'd0);
        check("ef_bank_lo", 32'(ef_bank), 32'd0);
        access(13'h1FEF, 8'h00, 4, EV_NONE, 14'd0);
        check("ef_bank_hi", 32'(ef_bank), 32'd15);

        // RAM disabled: the write window is plain ROM.
        sc = 1'b0;
        access(13'h1005, 8'h5A, 4, EV_NONE, 14'd0);
        check("nosc_ram_sel", 32'(ef_ram_sel), 32'd0);
        check("nosc_oe", 32'(ef_oe), 32'hFF);
        check("nosc_ram_rw", 32'(f8_ram_rw), 32'd1);

        // Long hold commits once.
        access(13'h1FF8, 8'h00, 20, EV_BANK, 14'd0);
        check("hold_bank", 32'(f8_bank), 32'd0);

        // Reset mid-settle aborts the pending commit.
        access(13'h1FF9, 8'h00, 4, EV_BANK, 14'd1);
        access(13'h1FF8, 8'h00, 2, EV_NONE, 14'd0);
        reset = 1'b1;
        #2;
        check("midrst_f8_bank", 32'(f8_bank), 32'd1);
        check("midrst_ef_bank", 32'(ef_bank), 32'd15);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_commit", 32'(f8_bank), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
